// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges byte streams from NUM_REQ requesters into one
// UART transmitter, optionally prefixing each packet with a channel header byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int HDR_EN  = 1,
    parameter int MAX_LEN = 255
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    input  logic                 txrdy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 trunc
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [7:0]       LEN_LIMIT = 8'(MAX_LEN);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, ISSUE, SETTLE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [7:0]       cnt;
    logic [7:0]       cnt_inc;
    logic             at_limit;
    logic             pkt_done;
    logic [7:0]       lane [NUM_REQ];
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane[i] = req_data[8*i +: 8];
        end
    end

    assign sel_valid = req_valid[gidx];
    assign sel_last  = req_last[gidx];
    assign sel_data  = lane[gidx];
    assign cnt_inc   = cnt + 8'd1;
    assign at_limit  = (cnt_inc == LEN_LIMIT);
    assign busy      = |grant;

    // Scan downwards so the last hit wins: that is the first valid requester after ptr.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Accept strobe is combinational so the byte is taken in the same cycle it is captured.
    always_comb begin
        req_ready = '0;
        if (state == DATA && txrdy) begin
            req_ready = grant & req_valid;
        end
    end

    // NOTE: state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            cnt      <= '0;
            pkt_done <= 1'b0;
            tx_data  <= 8'h00;
            tx_wr    <= 1'b0;
            trunc    <= 1'b0;
        end else begin
            tx_wr <= 1'b0;
            trunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= ONE_HOT0 << pick;
                        gidx  <= pick;
                        cnt   <= '0;
                        state <= (HDR_EN != 0) ? HDR : DATA;
                    end
                end
                HDR: begin
                    if (txrdy) begin
                        tx_data  <= {4'hA, 4'(gidx)};
                        tx_wr    <= 1'b1;
                        pkt_done <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                DATA: begin
                    if (txrdy && sel_valid) begin
                        tx_data  <= sel_data;
                        tx_wr    <= 1'b1;
                        cnt      <= cnt_inc;
                        pkt_done <= sel_last || at_limit;
                        trunc    <= !sel_last && at_limit;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    ptr <= gidx;
                    if (pkt_done) begin
                        grant <= '0;
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a scoreboard of expected
// transmitter writes, a packet table and hand-written stall/truncation/reset cases.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int ML = 4;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_wr;
    logic           txrdy;
    logic [N-1:0]   grant;
    logic           busy;
    logic           trunc;

    uart_tx_arbiter #(.NUM_REQ(N), .HDR_EN(1), .MAX_LEN(ML)) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .txrdy     (txrdy),
        .grant     (grant),
        .busy      (busy),
        .trunc     (trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } rbyte_t;

    typedef struct packed {
        logic [7:0]   data;
        logic         trunc;
        logic [N-1:0] grant;
        int           gap;
    } exp_t;

    typedef struct {
        int           req;
        int           len;
        logic [7:0]   base;
        logic [7:0]   step;
        logic [7:0]   exp_hdr;
        logic [N-1:0] exp_grant;
    } vec_t;

    rbyte_t rq [N][$];
    exp_t   sb [$];
    int     checks   = 0;
    int     failures = 0;
    int     tx_count = 0;
    int     gap      = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic t, input logic [N-1:0] g, input int gp);
        exp_t e;
        e.data  = d;
        e.trunc = t;
        e.grant = g;
        e.gap   = gp;
        sb.push_back(e);
    endtask

    task automatic push_pkt(input int r, input logic [7:0] base, input logic [7:0] step,
                            input int len, input int hgap);
        rbyte_t b;
        push_exp(8'hA0 | 8'(r), 1'b0, N'(1) << r, hgap);
        for (int k = 0; k < len; k++) begin
            b.data = base + step * 8'(k);
            b.last = (k == len - 1);
            rq[r].push_back(b);
            push_exp(b.data, 1'b0, N'(1) << r, 3);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (!busy && sb.size() == 0 && rq_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_done"}, 32'(ok), 32'd1);
        check({name, "_grant_clr"}, 32'(grant), 32'd0);
    endtask

    task automatic wait_tx(input int target, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            if (tx_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_tx_seen"}, 32'(ok), 32'd1);
    endtask

    // Requester model: present the head of each queue, pop it when it was accepted.
    initial begin : driver
        logic [N-1:0] rdy_s;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            rdy_s = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (rdy_s[i] && req_valid[i]) void'(rq[i].pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq[i][0].data;
                    req_last[i]        = rq[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Transmitter-side monitor: every write is popped from the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!aresetn) begin
            gap = 100;
        end else begin
            gap++;
            if (tx_wr) begin
                tx_count++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got write %0h expected none", tx_data);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("tx_grant", 32'(grant), 32'(e.grant));
                    check("tx_trunc", 32'(trunc), 32'(e.trunc));
                    check("tx_busy", 32'(busy), 32'd1);
                    if (e.gap != 0) check("tx_gap", 32'(gap), 32'(e.gap));
                    else            check("tx_gap_min", 32'(gap >= 3), 32'd1);
                end
                gap = 0;
            end else if (trunc) begin
                check("trunc_without_wr", 32'(trunc), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t   vecs [4];
        rbyte_t b;
        int     base_cnt;
        bit     stall_ok;
        bit     found_issue;

        vecs[0] = '{2, 3, 8'h11, 8'h11, 8'hA2, 4'b0100};
        vecs[1] = '{1, 4, 8'h40, 8'h01, 8'hA1, 4'b0010};
        vecs[2] = '{3, 1, 8'h5A, 8'h01, 8'hA3, 4'b1000};
        vecs[3] = '{0, 2, 8'h0C, 8'h03, 8'hA0, 4'b0001};

        txrdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_wr", 32'(tx_wr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_trunc", 32'(trunc), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_wr", 32'(tx_wr), 32'd0);

        // All requesters valid with 1-byte packets: order 0,1,2,3,0.
        push_pkt(0, 8'hB0, 8'h00, 1, 0);
        push_pkt(1, 8'hB1, 8'h00, 1, 4);
        push_pkt(2, 8'hB2, 8'h00, 1, 4);
        push_pkt(3, 8'hB3, 8'h00, 1, 4);
        push_pkt(0, 8'hB4, 8'h00, 1, 4);
        wait_idle("rr_all");

        // Single-requester packets from the table.
        for (int v = 0; v < 4; v++) begin
            push_exp(vecs[v].exp_hdr, 1'b0, vecs[v].exp_grant, 0);
            for (int k = 0; k < vecs[v].len; k++) begin
                b.data = vecs[v].base + vecs[v].step * 8'(k);
                b.last = (k == vecs[v].len - 1);
                rq[vecs[v].req].push_back(b);
                push_exp(b.data, 1'b0, vecs[v].exp_grant, 3);
            end
            wait_idle($sformatf("vec%0d", v));
        end

        // Truncation at MAX_LEN, remainder regranted after the other requesters.
        for (int k = 0; k < 6; k++) begin
            b.data = 8'h61 + 8'(k);
            b.last = (k == 5);
            rq[1].push_back(b);
        end
        rq[0].push_back('{8'h70, 1'b1});
        rq[2].push_back('{8'h72, 1'b1});
        rq[3].push_back('{8'h73, 1'b1});
        push_exp(8'hA1, 1'b0, 4'b0010, 0);
        push_exp(8'h61, 1'b0, 4'b0010, 3);
        push_exp(8'h62, 1'b0, 4'b0010, 3);
        push_exp(8'h63, 1'b0, 4'b0010, 3);
        push_exp(8'h64, 1'b1, 4'b0010, 3);
        push_exp(8'hA2, 1'b0, 4'b0100, 4);
        push_exp(8'h72, 1'b0, 4'b0100, 3);
        push_exp(8'hA3, 1'b0, 4'b1000, 4);
        push_exp(8'h73, 1'b0, 4'b1000, 3);
        push_exp(8'hA0, 1'b0, 4'b0001, 4);
        push_exp(8'h70, 1'b0, 4'b0001, 3);
        push_exp(8'hA1, 1'b0, 4'b0010, 4);
        push_exp(8'h65, 1'b0, 4'b0010, 3);
        push_exp(8'h66, 1'b0, 4'b0010, 3);
        wait_idle("trunc");

        // Transmitter stalled for 50 cycles in DATA.
        base_cnt = tx_count;
        rq[3].push_back('{8'h91, 1'b0});
        rq[3].push_back('{8'h92, 1'b1});
        push_exp(8'hA3, 1'b0, 4'b1000, 0);
        push_exp(8'h91, 1'b0, 4'b1000, 0);
        push_exp(8'h92, 1'b0, 4'b1000, 3);
        wait_tx(base_cnt + 1, "stall_hdr");
        txrdy = 1'b0;
        stall_ok = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (tx_wr || req_ready != '0) stall_ok = 1'b0;
        end
        check("stall_quiet", 32'(stall_ok), 32'd1);
        check("stall_busy", 32'(grant), 32'b1000);
        txrdy = 1'b1;
        #1;
        check("stall_ready", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        check("stall_wr_latency", 32'(tx_wr), 32'd1);
        check("stall_wr_data", 32'(tx_data), 32'h91);
        wait_idle("stall");

        // Reset during ISSUE of the second data byte.
        base_cnt = tx_count;
        rq[2].push_back('{8'h21, 1'b0});
        rq[2].push_back('{8'h22, 1'b0});
        rq[2].push_back('{8'h23, 1'b1});
        push_exp(8'hA2, 1'b0, 4'b0100, 0);
        push_exp(8'h21, 1'b0, 4'b0100, 3);
        wait_tx(base_cnt + 2, "rst_mid");
        found_issue = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (tx_wr) begin
                found_issue = 1'b1;
                break;
            end
        end
        check("rst_mid_issue_seen", 32'(found_issue), 32'd1);
        aresetn = 1'b0;
        #1;
        check("rst_mid_tx_wr", 32'(tx_wr), 32'd0);
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_sb_empty", 32'(sb.size()), 32'd0);
        rq[0].push_back('{8'h30, 1'b1});
        push_exp(8'hA0, 1'b0, 4'b0001, 0);
        push_exp(8'h30, 1'b0, 4'b0001, 3);
        push_exp(8'hA2, 1'b0, 4'b0100, 4);
        push_exp(8'h23, 1'b0, 4'b0100, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_first_no_wr", 32'(tx_wr), 32'd0);
        for (int n = 0; n < 20 && !busy; n++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_first_grant", 32'(grant), 32'b0001);
        wait_idle("rst_mid_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
